// File: rtl/regfile_sb.sv
// regfile_sb: parametrised two-read / one-write register file with a
// per-register busy scoreboard for RAW hazard detection in decode.
// Register 0 is optionally hardwired to zero (ZERO_REG).
// Optional feature macro: REGFILE_SB_BYPASS_EN. When defined, a writeback in
// the current cycle is forwarded to the read ports and clears the matching
// BUSY output in that same cycle. When undefined, reads and busy flags reflect
// registered state only.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE,
  input  logic            ISS,
  input  logic [AW-1:0]   ISS_RD,
  output logic            BUSY1,
  output logic            BUSY2,
  output logic            HAZ,
  output logic [AW:0]     PEND
);

  localparam int NREG = 2 ** AW;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     pend;
  logic [AW:0]     pend_nxt;

  logic            wr_ok;
  logic            iss_ok;
  logic [XLEN-1:0] rd1_raw;
  logic [XLEN-1:0] rd2_raw;
  logic            busy1_raw;
  logic            busy2_raw;

  // Writes and issues aimed at a hardwired-zero r0 are ignored entirely.
  assign wr_ok  = WE  && !((ZERO_REG != 0) && (A3 == '0));
  assign iss_ok = ISS && !((ZERO_REG != 0) && (ISS_RD == '0));

  // Next busy vector: retire clears, issue sets; set applied last so a new
  // producer to the same register supersedes the retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[A3]     = 1'b0;
    if (iss_ok) busy_nxt[ISS_RD] = 1'b1;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt = pend_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // Register array: asynchronous clear, one write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_ok) begin
      rf[A3] <= WD3;
    end
  end

  // Scoreboard state and its pending count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy <= '0;
      pend <= '0;
    end else begin
      busy <= busy_nxt;
      pend <= pend_nxt;
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = wr_ok && (A3 == A1);
  assign byp2 = wr_ok && (A3 == A2);

  // Read ports with write-through forwarding; a same-cycle reissue keeps busy.
  always_comb begin
    rd1_raw   = byp1 ? WD3 : rf[A1];
    rd2_raw   = byp2 ? WD3 : rf[A2];
    busy1_raw = busy[A1] && !(byp1 && !(iss_ok && (ISS_RD == A1)));
    busy2_raw = busy[A2] && !(byp2 && !(iss_ok && (ISS_RD == A2)));
  end
`else
  // Read ports straight from registered state.
  always_comb begin
    rd1_raw   = rf[A1];
    rd2_raw   = rf[A2];
    busy1_raw = busy[A1];
    busy2_raw = busy[A2];
  end
`endif

  // Outputs forced quiet while reset is asserted.
  assign RD1   = RST_N ? rd1_raw : '0;
  assign RD2   = RST_N ? rd2_raw : '0;
  assign BUSY1 = RST_N && busy1_raw;
  assign BUSY2 = RST_N && busy2_raw;
  assign HAZ   = BUSY1 || BUSY2;
  assign PEND  = pend;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus with an architectural model of the register
// file and scoreboard, checked every cycle, plus literal expectations.
// Honours REGFILE_SB_BYPASS_EN the same way as the design.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [AW-1:0]   A1, A2, A3, ISS_RD;
  logic [XLEN-1:0] WD3, RD1, RD2;
  logic            WE, ISS, BUSY1, BUSY2, HAZ;
  logic [AW:0]     PEND;

  int n_chk  = 0;
  int n_pass = 0;

  logic [XLEN-1:0] m_rf   [NREG];
  logic            m_busy [NREG];

  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .A3(A3), .WD3(WD3), .WE(WE), .ISS(ISS), .ISS_RD(ISS_RD),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .HAZ(HAZ), .PEND(PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Architectural model: r0 is constant zero, a retire clears, an issue sets.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        m_rf[i]   <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (WE && A3 != 0) begin
        m_rf[A3]   <= WD3;
        m_busy[A3] <= 1'b0;
      end
      if (ISS && ISS_RD != 0) m_busy[ISS_RD] <= 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (!RST_N) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (WE && A3 != 0 && A3 == a) return WD3;
`endif
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!RST_N) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (WE && A3 != 0 && A3 == a && !(ISS && ISS_RD == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_pend();
    int c = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("RD1",   RD1, exp_rd(A1));
      chk("RD2",   RD2, exp_rd(A2));
      chk("BUSY1", 32'(BUSY1), 32'(exp_busy(A1)));
      chk("BUSY2", 32'(BUSY2), 32'(exp_busy(A2)));
      chk("HAZ",   32'(HAZ),   32'(exp_busy(A1) | exp_busy(A2)));
      chk("PEND",  32'(PEND),  32'(exp_pend()));
    end
  end

  initial begin
    RST_N = 1'b0; WE = 1'b0; ISS = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; ISS_RD = '0; WD3 = '0;
    @(posedge CLK); @(negedge CLK);
    chk("reset_pend", 32'(PEND), 32'd0);
    chk("reset_rd1",  RD1, 32'd0);
    step();
    RST_N = 1'b1;

    // basic write then read on both ports
    WE = 1'b1; A3 = 5'd7; WD3 = 32'h12345678;
    step();
    WE = 1'b0; A1 = 5'd7; A2 = 5'd7;
    @(negedge CLK);
    chk("wr7_rd1", RD1, 32'h12345678);
    chk("wr7_rd2", RD2, 32'h12345678);
    step();

    // write to r0 is dropped
    WE = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF;
    step();
    WE = 1'b0; A1 = 5'd0;
    @(negedge CLK);
    chk("r0_rd1", RD1, 32'd0);
    step();

    // issue r3, then retire it
    ISS = 1'b1; ISS_RD = 5'd3;
    step();
    ISS = 1'b0; A1 = 5'd3;
    @(negedge CLK);
    chk("iss3_busy1", 32'(BUSY1), 32'd1);
    chk("iss3_haz",   32'(HAZ),   32'd1);
    chk("iss3_pend",  32'(PEND),  32'd1);
    step();
    WE = 1'b1; A3 = 5'd3; WD3 = 32'h33;
    step();
    WE = 1'b0;
    @(negedge CLK);
    chk("ret3_busy1", 32'(BUSY1), 32'd0);
    chk("ret3_pend",  32'(PEND),  32'd0);
    step();

    // same-register collision: set wins
    ISS = 1'b1; ISS_RD = 5'd4;
    step();
    WE = 1'b1; A3 = 5'd4; WD3 = 32'h44;
    step();
    WE = 1'b0; ISS = 1'b0; A1 = 5'd4;
    @(negedge CLK);
    chk("col4_busy1", 32'(BUSY1), 32'd1);
    chk("col4_pend",  32'(PEND),  32'd1);
    step();

    // different-register collision: both apply
    ISS = 1'b1; ISS_RD = 5'd9;
    step();
    ISS_RD = 5'd8; WE = 1'b1; A3 = 5'd9; WD3 = 32'h99;
    step();
    ISS = 1'b0; WE = 1'b0; A1 = 5'd8; A2 = 5'd9;
    @(negedge CLK);
    chk("col89_busy8", 32'(BUSY1), 32'd1);
    chk("col89_busy9", 32'(BUSY2), 32'd0);
    chk("col89_pend",  32'(PEND),  32'd2);
    step();
    WE = 1'b1; A3 = 5'd4; step();
    A3 = 5'd8; step();
    WE = 1'b0;
    @(negedge CLK);
    chk("drain_pend", 32'(PEND), 32'd0);
    step();

    // bypass case: r10 = 1 and busy, then write 0xAA while reading on port 2
    WE = 1'b1; A3 = 5'd10; WD3 = 32'h1; ISS = 1'b1; ISS_RD = 5'd10;
    step();
    ISS = 1'b0; WD3 = 32'hAA; A2 = 5'd10;
    @(negedge CLK);
`ifdef REGFILE_SB_BYPASS_EN
    chk("byp_rd2",   RD2, 32'hAA);
    chk("byp_busy2", 32'(BUSY2), 32'd0);
    chk("byp_haz",   32'(HAZ),   32'd0);
`else
    chk("byp_rd2",   RD2, 32'h1);
    chk("byp_busy2", 32'(BUSY2), 32'd1);
    chk("byp_haz",   32'(HAZ),   32'd1);
`endif
    step();
    WE = 1'b0;
    @(negedge CLK);
    chk("post_rd2",   RD2, 32'hAA);
    chk("post_busy2", 32'(BUSY2), 32'd0);
    step();

    // fill every register, then retire all
    for (int i = 0; i < NREG; i++) begin
      ISS = 1'b1; ISS_RD = 5'(i);
      step();
    end
    ISS = 1'b0;
    @(negedge CLK);
    chk("fill_pend", 32'(PEND), 32'd31);
    step();
    for (int i = 0; i < NREG; i++) begin
      WE = 1'b1; A3 = 5'(i); WD3 = 32'(i * 3 + 1);
      step();
    end
    WE = 1'b0;
    @(negedge CLK);
    chk("empty_pend", 32'(PEND), 32'd0);
    step();

    // retire and reissue of the same busy register keeps it busy
    ISS = 1'b1; ISS_RD = 5'd11;
    step();
    WE = 1'b1; A3 = 5'd11; WD3 = 32'hB0B; A1 = 5'd11;
    @(negedge CLK);
    chk("reiss_busy1", 32'(BUSY1), 32'd1);
    step();
    WE = 1'b0; ISS = 1'b0;

    // asynchronous reset mid-operation
    WE = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; ISS = 1'b1; ISS_RD = 5'd5;
    step();
    WE = 1'b0; ISS = 1'b0; A1 = 5'd5;
    @(negedge CLK);
    chk("r5_rd1",   RD1, 32'hDEADBEEF);
    chk("r5_busy1", 32'(BUSY1), 32'd1);
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_rd1",   RD1, 32'd0);
    chk("arst_busy1", 32'(BUSY1), 32'd0);
    chk("arst_pend",  32'(PEND),  32'd0);
    #3 RST_N = 1'b1;
    step();
    @(negedge CLK);
    chk("after_rst_rd1",  RD1, 32'd0);
    chk("after_rst_pend", 32'(PEND), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
